// File: rtl/ksk_rd_pkg.sv
// Shared types and constants for the KSK buffer read sequencer.
package ksk_rd_pkg;

    localparam int unsigned KSK_WORDS   = 12;
    localparam int unsigned KSK_ADDR_W  = 12;
    localparam int unsigned KSK_STAGE_W = 4;
    localparam int unsigned LEN_W       = 13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } seq_state_e;

endpackage

// File: rtl/ksk_rd_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module ksk_rd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // Pointer and occupancy next-state; pointers wrap at DEPTH so any depth works.
    always_comb begin
        do_pop   = i_pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (i_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!i_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (i_push) begin
            mem_q[wr_ptr_q] <= i_din;
        end
    end

    assign o_valid = (count_q != '0);
    assign o_dout  = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_count = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !do_pop && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/ksk_rd_sequencer.sv
// KSK stage read sequencer: issues buffer addresses under credit control,
// tracks the fixed read latency and presents beats through a FWFT FIFO.
// Optional feature macro: KSK_RD_STALL_CNT_EN adds o_stall_cnt.
module ksk_rd_sequencer
    import ksk_rd_pkg::*;
#(
    parameter int unsigned KSK_DATA_WIDTH = 39,
    parameter int unsigned RAM_DELAY      = 3,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
`ifdef KSK_RD_STALL_CNT_EN
    output logic [31:0]                         o_stall_cnt,
`endif
    input  logic                                i_seq_start,
    input  logic [KSK_STAGE_W-1:0]              i_seq_stage,
    input  logic [LEN_W-1:0]                    i_seq_len,
    output logic                                o_seq_busy,
    output logic                                o_seq_done,
    output logic [KSK_STAGE_W-1:0]              o_ksk_stage,
    output logic [KSK_ADDR_W-1:0]               o_ksk_rdaddr,
    input  logic [KSK_WORDS*KSK_DATA_WIDTH-1:0] i_ksk_rddata,
    output logic                                o_seq_valid,
    input  logic                                i_seq_ready,
    output logic [KSK_WORDS*KSK_DATA_WIDTH-1:0] o_seq_data,
    output logic                                o_seq_last
);

    localparam int unsigned BEAT_W = KSK_WORDS * KSK_DATA_WIDTH;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < RAM_DELAY + 2) begin : g_depth_check
        $error("ksk_rd_sequencer: FIFO_DEPTH must be at least RAM_DELAY+2");
    end

    seq_state_e              state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [KSK_STAGE_W-1:0]  stage_q, stage_d;
    logic [KSK_ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        nxt_q, nxt_d;
    logic                    issue_v_q, issue_v_d;
    logic                    issue_l_q, issue_l_d;
    logic [RAM_DELAY-1:0]    pipe_v_q, pipe_v_d;
    logic [RAM_DELAY-1:0]    pipe_l_q, pipe_l_d;

    logic                    start_ok;
    logic                    credit_ok;
    int unsigned             inflight;
    logic                    fifo_valid;
    logic                    fifo_pop;
    logic [BEAT_W:0]         fifo_dout;
    logic [CNT_W-1:0]        fifo_count;

    assign fifo_pop = fifo_valid && i_seq_ready;

    // FSM, address issue, credit check and latency pipeline next-state.
    // The issue flop holds the address currently on the bus, so it counts as in flight.
    always_comb begin
        start_ok = i_seq_start && !busy_q && !done_q;
        inflight = 32'(issue_v_q);
        for (int unsigned i = 0; i < RAM_DELAY; i++) begin
            inflight = inflight + 32'(pipe_v_q[i]);
        end
        credit_ok = (inflight + 32'(fifo_count)) < FIFO_DEPTH;

        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        stage_d   = stage_q;
        addr_d    = addr_q;
        len_d     = len_q;
        nxt_d     = nxt_q;
        issue_v_d = 1'b0;
        issue_l_d = 1'b0;

        pipe_v_d[0] = issue_v_q;
        pipe_l_d[0] = issue_l_q;
        for (int unsigned i = 1; i < RAM_DELAY; i++) begin
            pipe_v_d[i] = pipe_v_q[i-1];
            pipe_l_d[i] = pipe_l_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    stage_d = i_seq_stage;
                    len_d   = i_seq_len;
                    if (i_seq_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d    = 1'b1;
                        addr_d    = '0;
                        nxt_d     = LEN_W'(1);
                        issue_v_d = 1'b1;
                        issue_l_d = (i_seq_len == LEN_W'(1));
                        state_d   = issue_l_d ? S_DRAIN : S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (credit_ok) begin
                    addr_d    = nxt_q[KSK_ADDR_W-1:0];
                    nxt_d     = nxt_q + LEN_W'(1);
                    issue_v_d = 1'b1;
                    issue_l_d = (nxt_q == len_q - LEN_W'(1));
                    if (issue_l_d) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_pop && fifo_dout[BEAT_W]) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stage_q   <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            nxt_q     <= '0;
            issue_v_q <= 1'b0;
            issue_l_q <= 1'b0;
            pipe_v_q  <= '0;
            pipe_l_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            stage_q   <= stage_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            nxt_q     <= nxt_d;
            issue_v_q <= issue_v_d;
            issue_l_q <= issue_l_d;
            pipe_v_q  <= pipe_v_d;
            pipe_l_q  <= pipe_l_d;
        end
    end

    ksk_rd_fifo #(
        .WIDTH (BEAT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (pipe_v_q[RAM_DELAY-1]),
        .i_din   ({pipe_l_q[RAM_DELAY-1], i_ksk_rddata}),
        .i_pop   (fifo_pop),
        .o_dout  (fifo_dout),
        .o_valid (fifo_valid),
        .o_count (fifo_count)
    );

    assign o_seq_busy   = busy_q;
    assign o_seq_done   = done_q;
    assign o_ksk_stage  = stage_q;
    assign o_ksk_rdaddr = addr_q;
    assign o_seq_valid  = fifo_valid;
    assign o_seq_data   = fifo_dout[BEAT_W-1:0];
    assign o_seq_last   = fifo_dout[BEAT_W];

`ifdef KSK_RD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a beat waits on downstream.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_ok) begin
            stall_cnt_d = '0;
        end else if (fifo_valid && !i_seq_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ksk_rd_sequencer.sv
// Directed self-checking bench for ksk_rd_sequencer.
module tb_ksk_rd_sequencer;
    import ksk_rd_pkg::*;

    localparam int DW = 39;
    localparam int BW = 12 * DW;
    localparam int RD = 3;

    logic          clk;
    logic          rst_n;
    logic          i_seq_start;
    logic [3:0]    i_seq_stage;
    logic [12:0]   i_seq_len;
    logic          o_seq_busy;
    logic          o_seq_done;
    logic [3:0]    o_ksk_stage;
    logic [11:0]   o_ksk_rdaddr;
    logic [BW-1:0] i_ksk_rddata;
    logic          o_seq_valid;
    logic          i_seq_ready;
    logic [BW-1:0] o_seq_data;
    logic          o_seq_last;
`ifdef KSK_RD_STALL_CNT_EN
    logic [31:0]   o_stall_cnt;
`endif

    int vectors;
    int miscompares;

    ksk_rd_sequencer #(
        .KSK_DATA_WIDTH (DW),
        .RAM_DELAY      (RD),
        .FIFO_DEPTH     (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef KSK_RD_STALL_CNT_EN
        .o_stall_cnt  (o_stall_cnt),
`endif
        .i_seq_start  (i_seq_start),
        .i_seq_stage  (i_seq_stage),
        .i_seq_len    (i_seq_len),
        .o_seq_busy   (o_seq_busy),
        .o_seq_done   (o_seq_done),
        .o_ksk_stage  (o_ksk_stage),
        .o_ksk_rdaddr (o_ksk_rdaddr),
        .i_ksk_rddata (i_ksk_rddata),
        .o_seq_valid  (o_seq_valid),
        .i_seq_ready  (i_seq_ready),
        .o_seq_data   (o_seq_data),
        .o_seq_last   (o_seq_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model contents: each word encodes its address and word index.
    function automatic logic [BW-1:0] ram_word(input logic [11:0] a);
        logic [BW-1:0] r;
        logic [3:0]    k4;
        r = '0;
        for (int k = 0; k < 12; k++) begin
            k4 = 4'(k);
            r[k*DW +: DW] = {3'b101, k4, a, ~a, a[7:0]};
        end
        return r;
    endfunction

    // Buffer model read latency: data for an address appears RD cycles later.
    logic [11:0] ad [RD];
    always @(posedge clk) begin
        ad[0] <= o_ksk_rdaddr;
        for (int i = 1; i < RD; i++) ad[i] <= ad[i-1];
    end
    assign i_ksk_rddata = ram_word(ad[RD-1]);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts one operation in the current cycle and follows it to completion,
    // checking every accepted beat against the buffer model.
    task automatic run_op(input logic [3:0] stage, input int len, input int low_pct,
                          input int inject_at, input int stop_after, input int budget,
                          output int beats, output int first_cyc, output int last_hs,
                          output int done_cyc, output int gaps, output int max_cnt);
        logic          prev_stall;
        logic [BW-1:0] prev_data;
        int            c;
        beats = 0; first_cyc = -1; last_hs = -1; done_cyc = -1; gaps = 0; max_cnt = 0;
        prev_stall = 1'b0; prev_data = '0;
        i_seq_stage = stage;
        i_seq_len   = 13'(len);
        i_seq_start = 1'b1;
        i_seq_ready = 1'b1;
        step();
        i_seq_start = 1'b0;
        c = 1;
        check("first_addr", 512'(o_ksk_rdaddr), 512'(0));
        check("busy_after_start", 512'(o_seq_busy), 512'(1));
        while (c < budget) begin
            if (stop_after > 0 && beats == stop_after) break;
            if (o_seq_done) begin
                done_cyc = c;
                break;
            end
            i_seq_ready = (low_pct == 0) ? 1'b1 : (int'($urandom_range(0, 99)) >= low_pct);
            if (c == inject_at) begin
                i_seq_start = 1'b1;
                i_seq_stage = 4'd2;
            end else begin
                i_seq_start = 1'b0;
            end
            if (prev_stall) begin
                check("hold_valid", 512'(o_seq_valid), 512'(1));
                check("hold_data", 512'(o_seq_data), 512'(prev_data));
            end
            if (int'(dut.u_fifo.o_count) > max_cnt) max_cnt = int'(dut.u_fifo.o_count);
            if (o_seq_valid && i_seq_ready) begin
                check("beat_data", 512'(o_seq_data), 512'(ram_word(12'(beats))));
                check("beat_last", 512'(o_seq_last), 512'(beats == len - 1));
                if (beats == 0) first_cyc = c;
                else if (c != last_hs + 1) gaps++;
                last_hs = c;
                beats++;
            end
            prev_stall = o_seq_valid && !i_seq_ready;
            prev_data  = o_seq_data;
            step();
            c++;
        end
        i_seq_start = 1'b0;
        i_seq_ready = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},  512'(o_seq_busy),   512'(0));
        check({tag, "_done"},  512'(o_seq_done),   512'(0));
        check({tag, "_valid"}, 512'(o_seq_valid),  512'(0));
        check({tag, "_last"},  512'(o_seq_last),   512'(0));
        check({tag, "_stage"}, 512'(o_ksk_stage),  512'(0));
        check({tag, "_addr"},  512'(o_ksk_rdaddr), 512'(0));
        check({tag, "_data"},  512'(o_seq_data),   512'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats, first_cyc, last_hs, done_cyc, gaps, max_cnt;
        logic [11:0] addr_before;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        i_seq_start = 1'b0;
        i_seq_stage = '0;
        i_seq_len = '0;
        i_seq_ready = 1'b1;
        step();
        step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();
        step();

        // Nominal full-length stream with an ignored start injected mid-stream.
        run_op(4'd5, 4096, 0, 200, 0, 4300, beats, first_cyc, last_hs, done_cyc, gaps, max_cnt);
        check("nom_beats", 512'(beats), 512'(4096));
        check("nom_first_valid_cycle", 512'(first_cyc), 512'(5));
        check("nom_gaps", 512'(gaps), 512'(0));
        check("nom_done_cycle", 512'(done_cyc), 512'(last_hs + 1));
        check("nom_busy_at_done", 512'(o_seq_busy), 512'(0));
        check("nom_stage_kept", 512'(o_ksk_stage), 512'(5));
        check("nom_last_addr", 512'(o_ksk_rdaddr), 512'(12'hFFF));

        // Start coinciding with the done pulse is ignored.
        i_seq_start = 1'b1;
        i_seq_stage = 4'd9;
        i_seq_len = 13'd1;
        step();
        i_seq_start = 1'b0;
        check("start_at_done_busy", 512'(o_seq_busy), 512'(0));
        check("start_at_done_stage", 512'(o_ksk_stage), 512'(5));
        step();

        // Backpressure with ~30% ready low.
        run_op(4'd5, 20, 30, 0, 0, 400, beats, first_cyc, last_hs, done_cyc, gaps, max_cnt);
        check("bp_beats", 512'(beats), 512'(20));
        check("bp_done_cycle", 512'(done_cyc), 512'(last_hs + 1));
        check("bp_fifo_max_le_8", 512'(max_cnt <= 8), 512'(1));
        check("bp_valid_at_done", 512'(o_seq_valid), 512'(0));
        check("bp_last_addr", 512'(o_ksk_rdaddr), 512'(19));

        // Zero-length operation.
        step();
        addr_before = o_ksk_rdaddr;
        i_seq_start = 1'b1;
        i_seq_stage = 4'd3;
        i_seq_len = 13'd0;
        step();
        i_seq_start = 1'b0;
        check("zero_done_c1", 512'(o_seq_done), 512'(1));
        check("zero_busy_c1", 512'(o_seq_busy), 512'(0));
        check("zero_valid_c1", 512'(o_seq_valid), 512'(0));
        check("zero_addr_c1", 512'(o_ksk_rdaddr), 512'(addr_before));
        step();
        check("zero_done_c2", 512'(o_seq_done), 512'(0));
        check("zero_valid_c2", 512'(o_seq_valid), 512'(0));
        step();
        check("zero_valid_c3", 512'(o_seq_valid), 512'(0));
        check("zero_addr_c3", 512'(o_ksk_rdaddr), 512'(addr_before));

        // Reset asserted after 10 beats of a longer stream.
        run_op(4'd6, 100, 0, 0, 10, 300, beats, first_cyc, last_hs, done_cyc, gaps, max_cnt);
        check("rst_beats_before", 512'(beats), 512'(10));
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        step();
        rst_n = 1'b1;
        step();
        step();
        run_op(4'd7, 3, 0, 0, 0, 100, beats, first_cyc, last_hs, done_cyc, gaps, max_cnt);
        check("post_rst_beats", 512'(beats), 512'(3));
        check("post_rst_first_valid", 512'(first_cyc), 512'(5));
        check("post_rst_done_cycle", 512'(done_cyc), 512'(last_hs + 1));
        check("post_rst_stage", 512'(o_ksk_stage), 512'(7));

`ifdef KSK_RD_STALL_CNT_EN
        // Stall counter: seven ready-low cycles while a beat waits.
        begin
            int n;
            step();
            i_seq_start = 1'b1;
            i_seq_stage = 4'd1;
            i_seq_len = 13'd3;
            i_seq_ready = 1'b0;
            step();
            i_seq_start = 1'b0;
            n = 0;
            while (!o_seq_valid && n < 20) begin
                step();
                n++;
            end
            check("stall_valid_seen", 512'(o_seq_valid), 512'(1));
            for (int i = 0; i < 7; i++) step();
            check("stall_cnt_7", 512'(o_stall_cnt), 512'(7));
            i_seq_ready = 1'b1;
            n = 0;
            while (!o_seq_done && n < 40) begin
                step();
                n++;
            end
            check("stall_done_seen", 512'(o_seq_done), 512'(1));
            step();
            i_seq_start = 1'b1;
            i_seq_len = 13'd1;
            step();
            i_seq_start = 1'b0;
            check("stall_cnt_cleared", 512'(o_stall_cnt), 512'(0));
            n = 0;
            while (!o_seq_done && n < 40) begin
                step();
                n++;
            end
            check("stall_second_done", 512'(o_seq_done), 512'(1));
        end
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
